// File: rtl/exu_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the default bus watchdog limit.
package exu_lsu_pkg;

  // Access size encodings (2'b11 is reserved and always treated as misaligned)
  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  // FSM states
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ISSUE = 2'b01;
  localparam logic [1:0] WAIT  = 2'b10;
  localparam logic [1:0] EXC   = 2'b11;

  // Default bus response watchdog limit, in cycles
  localparam int unsigned LSU_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/exu_lsu_align.sv
// Combinational alignment helper for the LSU. The store path steers the
// write data onto byte lanes, builds the byte strobes and flags misaligned
// accesses; the load path moves the addressed byte/half down to bit 0 and
// sign- or zero-extends it. One instance serves each direction.
module exu_lsu_align
  import exu_lsu_pkg::*;
(
  input  logic [31:0] st_data,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] ld_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic        misalign,
  output logic [31:0] ld_result
);

  logic [31:0] ld_shifted;

  // Store lane replication, strobe generation and alignment check
  always_comb begin
    misalign = (size == 2'b11) ||
               ((size == LSU_SIZE_H) && addr_lo[0]) ||
               ((size == LSU_SIZE_W) && (addr_lo != 2'b00));
    case (size)
      LSU_SIZE_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << addr_lo;
      end
      LSU_SIZE_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = 4'b0011 << addr_lo;
      end
      default: begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load extraction: shift the addressed lane to bit 0, then extend
  always_comb begin
    ld_shifted = ld_data >> {addr_lo, 3'b000};
    case (size)
      LSU_SIZE_B: ld_result = is_unsigned ? {24'h0, ld_shifted[7:0]}
                                          : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      LSU_SIZE_H: ld_result = is_unsigned ? {16'h0, ld_shifted[15:0]}
                                          : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      default:    ld_result = ld_data;
    endcase
  end

endmodule

// File: rtl/exu_lsu.sv
// Load/store unit: accepts one memory operation from the EXU at a time,
// checks alignment, drives a single-outstanding valid/ready bus and returns
// load data to writeback. All outputs are registered.
// Optional feature macro EXU_LSU_TIMEOUT_EN adds a bus response watchdog
// (parameter TIMEOUT_CYCLES) and the o_bus_err pulse output.
module exu_lsu
  import exu_lsu_pkg::*;
`ifdef EXU_LSU_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_mem_rreq,
  input  logic        i_mem_wreq,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [1:0]  i_mem_size,
  input  logic        i_mem_unsigned,
  input  logic [4:0]  i_rd_idx,
  output logic        o_bus_valid,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wstrb,
  input  logic        i_bus_ready,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_st_done,
  output logic        o_misalign,
`ifdef EXU_LSU_TIMEOUT_EN
  output logic        o_bus_err,
`endif
  output logic        o_busy
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [4:0]  rd_q;
  logic        accept;
  logic        timeout;

  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic        st_misalign;
  logic [31:0] ld_result;
  logic [31:0] unused_st_ld_result;
  logic [31:0] unused_ld_wdata;
  logic [3:0]  unused_ld_wstrb;
  logic        unused_ld_misalign;

  // Request side: steer the incoming store and check alignment
  exu_lsu_align u_align_st (
    .st_data     (i_mem_wdata),
    .addr_lo     (i_mem_addr[1:0]),
    .size        (i_mem_size),
    .is_unsigned (i_mem_unsigned),
    .ld_data     (32'h0),
    .st_wdata    (st_wdata),
    .st_wstrb    (st_wstrb),
    .misalign    (st_misalign),
    .ld_result   (unused_st_ld_result)
  );

  // Response side: extract and extend the returned load data
  exu_lsu_align u_align_ld (
    .st_data     (32'h0),
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ld_data     (i_bus_rdata),
    .st_wdata    (unused_ld_wdata),
    .st_wstrb    (unused_ld_wstrb),
    .misalign    (unused_ld_misalign),
    .ld_result   (ld_result)
  );

`ifdef EXU_LSU_TIMEOUT_EN
  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;

  assign timeout = ((state_q == ISSUE) || (state_q == WAIT)) && (cnt_q == TimeoutLim);

  // Watchdog counts cycles spent in ISSUE/WAIT, restarting on any state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'h0;
    end else if (state_d != state_q) begin
      cnt_q <= 16'h0;
    end else if ((state_q == ISSUE) || (state_q == WAIT)) begin
      cnt_q <= cnt_q + 16'h1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic; a request with both rreq and wreq is a store
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_valid && (i_mem_rreq || i_mem_wreq)) begin
          accept  = 1'b1;
          state_d = st_misalign ? EXC : ISSUE;
        end
      end
      ISSUE: begin
        if (i_bus_ready)  state_d = o_bus_we ? IDLE : WAIT;
        else if (timeout) state_d = EXC;
      end
      WAIT: begin
        if (i_bus_rvalid) state_d = IDLE;
        else if (timeout) state_d = EXC;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operation latches and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_lo_q   <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      rd_q        <= 5'h0;
      o_req_ready <= 1'b1;
      o_busy      <= 1'b0;
      o_bus_valid <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= 32'h0;
      o_bus_wdata <= 32'h0;
      o_bus_wstrb <= 4'h0;
      o_wb_valid  <= 1'b0;
      o_wb_rd     <= 5'h0;
      o_wb_data   <= 32'h0;
      o_st_done   <= 1'b0;
      o_misalign  <= 1'b0;
`ifdef EXU_LSU_TIMEOUT_EN
      o_bus_err   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      o_req_ready <= (state_d == IDLE);
      o_busy      <= (state_d != IDLE);
      o_bus_valid <= (state_d == ISSUE);
      o_wb_valid  <= 1'b0;
      o_st_done   <= 1'b0;
      o_misalign  <= 1'b0;
`ifdef EXU_LSU_TIMEOUT_EN
      o_bus_err   <= timeout && (state_d == EXC);
`endif
      if (accept) begin
        addr_lo_q   <= i_mem_addr[1:0];
        size_q      <= i_mem_size;
        uns_q       <= i_mem_unsigned;
        rd_q        <= i_rd_idx;
        o_bus_we    <= i_mem_wreq;
        o_bus_addr  <= {i_mem_addr[31:2], 2'b00};
        o_bus_wdata <= i_mem_wreq ? st_wdata : 32'h0;
        o_bus_wstrb <= i_mem_wreq ? st_wstrb : 4'h0;
        o_misalign  <= st_misalign;
      end
      if ((state_q == ISSUE) && i_bus_ready && o_bus_we) begin
        o_st_done <= 1'b1;
      end
      if ((state_q == WAIT) && i_bus_rvalid) begin
        o_wb_valid <= 1'b1;
        o_wb_data  <= ld_result;
        o_wb_rd    <= rd_q;
      end
    end
  end

endmodule

// File: doc/exu_lsu.md
Name: exu_lsu

Overview:
- Load/store unit on the consumer side of the ALU decoder's memory request outputs (mem read/write request, address from the adder result).
- Accepts one memory operation at a time, performs the alignment check, and drives a single-outstanding valid/ready data bus.
- Returns load data to the writeback stage and stalls the pipeline while busy.

Parameters:
- TIMEOUT_CYCLES, 255, bus response watchdog limit; used only with the optional feature.

Ports:
clk  input  1  core clock
rst  input  1  asynchronous reset, active-high
i_req_valid  input  1  operation valid from EXU
o_req_ready  output  1  LSU can accept an operation (idle)
i_mem_rreq  input  1  load request
i_mem_wreq  input  1  store request
i_mem_addr  input  32  effective address (adder result)
i_mem_wdata  input  32  store data (rs2)
i_mem_size  input  2  00 byte, 01 half, 10 word, 11 reserved
i_mem_unsigned  input  1  zero-extend load (lbu/lhu)
i_rd_idx  input  5  load destination register
o_bus_valid  output  1  bus request valid
o_bus_we  output  1  1 = write
o_bus_addr  output  32  word-aligned address ({addr[31:2],2'b00})
o_bus_wdata  output  32  lane-replicated store data
o_bus_wstrb  output  4  byte enables
i_bus_ready  input  1  bus accepts request
i_bus_rvalid  input  1  read data valid
i_bus_rdata  input  32  read data
o_wb_valid  output  1  load result pulse
o_wb_rd  output  5  load destination
o_wb_data  output  32  extended load data
o_st_done  output  1  store completion pulse
o_misalign  output  1  misaligned-access exception pulse
o_busy  output  1  pipeline stall (state != IDLE)

Behaviour:
- All outputs are registered. Reset values: every output is 0, except o_req_ready = 1. The FSM resets to IDLE.
- FSM states:
  - IDLE: o_req_ready = 1.
    - Accept when i_req_valid & (rreq|wreq).
    - If both rreq and wreq are set, the operation is treated as a store.
    - If neither is set, the request is ignored.
    - On accept, latch addr[1:0], size, unsigned, rd, and the lane-steered wdata/wstrb.
    - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size 11): go to EXC, no bus access.
    - Otherwise go to ISSUE.
  - ISSUE: o_bus_valid = 1; address, we, wdata and wstrb are held stable until i_bus_ready.
    - On ready, a store goes to IDLE with o_st_done pulsed 1 cycle; a load goes to WAIT.
  - WAIT: on i_bus_rvalid, o_wb_data = extract(rdata, addr[1:0], size, unsigned), o_wb_rd = latched rd, o_wb_valid pulses 1 cycle, then go to IDLE.
  - EXC: o_misalign pulses 1 cycle, then go to IDLE.
- Latency:
  - Accept at cycle N gives o_bus_valid at N+1.
  - With zero-wait ready and rvalid at N+2, o_wb_valid is at N+3.
  - Best-case store: o_st_done at N+2.
- Store lanes:
  - Byte: wdata = {4{wdata[7:0]}}, wstrb = 0001 << addr[1:0].
  - Half: wdata = {2{wdata[15:0]}}, wstrb = 0011 << addr[1:0].
  - Word: wstrb = 1111.
- Loads: the selected byte or half is shifted to bit 0, then sign- or zero-extended per unsigned.
- i_bus_rvalid outside WAIT is ignored. i_req_valid while busy is ignored (ready = 0).
- Reset mid-operation: immediate return to IDLE, the pending transaction is dropped, and no pulses are emitted.

Optional Feature:
- Macro: EXU_LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter runs in ISSUE and WAIT and clears on every state change.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to EXC, o_misalign stays 0, and an extra output o_bus_err pulses 1 cycle.
  - A late rvalid is ignored.
- Undefined: no counter and no o_bus_err port; the LSU waits indefinitely.

Decomposition:
- Package exu_lsu_pkg:
  - size encodings LSU_SIZE_B/H/W;
  - FSM state localparams IDLE/ISSUE/WAIT/EXC (2-bit);
  - default TIMEOUT_CYCLES.
- Sub-module exu_lsu_align: purely combinational.
  - Store lane steering: wdata, wstrb, misalign flag.
  - Load extraction/extension.
  - Instantiated once for each direction.

Test Plan:
- lw addr 0x1000, bus ready immediately, rdata 0xDEADBEEF at N+2 -> o_bus_addr 0x1000, wstrb 0000, o_wb_valid at N+3 with data 0xDEADBEEF, rd echoed.
- lb addr 0x1003, rdata 0x80AA5511 -> data 0xFFFFFF80; lbu at the same address -> 0x00000080.
- sh addr 0x2002, wdata 0x12345678, i_bus_ready delayed 3 cycles -> wdata 0x56785678 and wstrb 1100 held stable, o_st_done one cycle after ready.
- lw addr 0x1001 -> no o_bus_valid, o_misalign pulse at N+1, o_req_ready back at N+2.
- rst asserted during WAIT, then rvalid arrives -> outputs at reset values, no o_wb_valid.
- With EXU_LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, load with no rvalid -> o_bus_err pulse after 4 WAIT cycles, FSM returns to IDLE.
